// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (priority) and a debug/loader port.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReqM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [DATA_W-1:0] OOR_DATA = DATA_W'(32'hDEADBEEF);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be within 1..255");
    end

    owner_t            owner_s;
    logic              dbg_oor_s;
    logic              guard_trip_s;
    logic              resp_s;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign dbg_oor_s = |dbg_addr[31:ADDR_W];

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign guard_trip_s = (starve_cnt_q == 8'(STARVE_LIMIT));
    assign StallM       = dbg_ready & MemReqM;

    // Count consecutive denied debug cycles, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dbg_valid || dbg_ready) begin
            starve_cnt_d = 8'd0;
        end else if (guard_trip_s) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= 8'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign guard_trip_s = 1'b0;
    assign StallM       = 1'b0;
`endif

    // Owner selection; a tripped guard overrides pipeline priority.
    always_comb begin
        owner_s = OWN_NONE;
        if (!rst) begin
            owner_s = OWN_NONE;
        end else if (MemReqM && dbg_valid && guard_trip_s) begin
            owner_s = OWN_DBG;
        end else if (MemReqM) begin
            owner_s = OWN_PIPE;
        end else if (dbg_valid) begin
            owner_s = OWN_DBG;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Memory port mux; address and data default to the pipeline values.
    always_comb begin
        mem_addr  = ALUResultM;
        mem_wdata = WriteDataM;
        mem_we    = 1'b0;
        ReadDataM = '0;
        dbg_ready = 1'b0;
        case (owner_s)
            OWN_PIPE: begin
                mem_we    = MemWriteM;
                ReadDataM = mem_rdata;
            end
            OWN_DBG: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                mem_we    = dbg_we & ~dbg_oor_s;
                dbg_ready = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Response: granted reads, and out-of-range writes (error only).
    always_comb begin
        resp_s   = dbg_ready & (~dbg_we | dbg_oor_s);
        rvalid_d = resp_s;
        err_d    = resp_s & dbg_oor_s;
        if (resp_s) begin
            rdata_d = dbg_oor_s ? OOR_DATA : mem_rdata;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Debug response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dbg_rvalid = rvalid_q;
    assign dbg_err    = err_q;
    assign dbg_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level reference model and memory array.
module tb_dmem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM;
    logic        dbg_valid, dbg_ready, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Environment memory: combinational read, write at the edge.
    logic [31:0] tb_mem [256];
    bit          mem_loaded = 1'b0;
    assign mem_rdata = tb_mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          denied;
    bit          exp_rvalid, exp_err, exp_rd_chk, last_gnt;
    logic [31:0] exp_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit mreq, input bit mwe, input logic [31:0] aaddr,
                        input logic [31:0] awd, input bit dv, input bit dwe,
                        input logic [31:0] daddr, input logic [31:0] dwd);
        bit oor, trip, gnt, pipe, ewe, resp;
        rst = r; MemReqM = mreq; MemWriteM = mwe; ALUResultM = aaddr; WriteDataM = awd;
        dbg_valid = dv; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
        #4;
        oor = (daddr >= 32'd256);
`ifdef DMEM_ARB_STARVE_GUARD_EN
        trip = (denied >= LIMIT);
`else
        trip = 1'b0;
`endif
        gnt  = r && dv && (!mreq || trip);
        pipe = r && mreq && !gnt;
        ewe  = pipe ? mwe : (gnt ? (dwe && !oor) : 1'b0);
        check_eq("dbg_ready", {31'd0, dbg_ready}, {31'd0, gnt});
        check_eq("StallM", {31'd0, StallM}, {31'd0, gnt && mreq});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, ewe});
        check_eq("mem_addr", mem_addr, gnt ? daddr : aaddr);
        check_eq("mem_wdata", mem_wdata, gnt ? dwd : awd);
        check_eq("ReadDataM", ReadDataM, pipe ? ref_mem[aaddr[7:0]] : 32'd0);
        check_eq("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, exp_rvalid});
        if (exp_rvalid || exp_rd_chk) check_eq("dbg_err", {31'd0, dbg_err}, {31'd0, exp_err});
        if (exp_rd_chk) check_eq("dbg_rdata", dbg_rdata, exp_rdata);
        // Effects of the coming edge
        resp = gnt && (!dwe || oor);
        if (!r) begin
            exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0; exp_rd_chk = 1'b1;
        end else begin
            exp_rvalid = resp;
            exp_err    = resp && oor;
            exp_rd_chk = resp && !dwe;
            if (exp_rd_chk) exp_rdata = oor ? 32'hDEAD_BEEF : ref_mem[daddr[7:0]];
        end
        if (ewe) begin
            if (gnt) ref_mem[daddr[7:0]] = dwd;
            else     ref_mem[aaddr[7:0]] = awd;
        end
        denied   = (!r || !dv || gnt) ? 0 : denied + 1;
        last_gnt = gnt;
        @(posedge clk);
        #1;
    endtask

    bit          p_v, p_we, r_v, m_v, m_we;
    logic [31:0] p_addr, p_wd;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        denied = 0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0; exp_rd_chk = 1'b1;
        last_gnt = 1'b0;
        rst = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with requests present while rst is low
        step(1'b0, 1'b1, 1'b1, 32'd2, 32'h11, 1'b1, 1'b1, 32'd3, 32'h22);

        // Idle pipeline: debug write then read of addr 4
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd4, 32'h0000_00AA);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0);
        check_eq("tp1_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check_eq("tp1_rdata", dbg_rdata, 32'h0000_00AA);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Pipeline store collides with a debug write to the same word
        step(1'b1, 1'b1, 1'b1, 32'd8, 32'h1234, 1'b1, 1'b1, 32'd8, 32'h5678);
        step(1'b1, 1'b1, 1'b0, 32'd9, 32'd0,    1'b1, 1'b1, 32'd8, 32'h5678);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,    1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0,    1'b1, 1'b0, 32'd8, 32'd0);
        check_eq("tp2_rdata", dbg_rdata, 32'h1234);

`ifdef DMEM_ARB_STARVE_GUARD_EN
        // Held contention: LIMIT pipeline cycles, then a forced debug grant
        for (int c = 0; c < LIMIT + 1; c++)
            step(1'b1, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
        check_eq("guard_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check_eq("guard_rdata", dbg_rdata, ref_mem[5]);
`endif
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Out-of-range write and read
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd300, 32'h1);
        check_eq("oor_w_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check_eq("oor_w_err", {31'd0, dbg_err}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd300, 32'd0);
        check_eq("oor_r_rdata", dbg_rdata, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 1'b0, 32'd44, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("oor_mem_kept", tb_mem[44], init_word(44));

        // Reset right after a granted read
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd4, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'd6, 32'h77, 1'b1, 1'b1, 32'd7, 32'h88);
        check_eq("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        check_eq("rst_rdata", dbg_rdata, 32'd0);

        // Randomized traffic honoring the debug handshake
        p_v = 1'b0; p_we = 1'b0; p_addr = 32'd0; p_wd = 32'd0; last_gnt = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!p_v || last_gnt) begin
                p_v    = ($urandom_range(0, 99) < 60);
                p_we   = $urandom_range(0, 1) == 1;
                p_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 5000))
                                                     : 32'($urandom_range(0, 15));
                p_wd   = $urandom;
            end
            r_v  = ($urandom_range(0, 99) >= 3);
            m_v  = ($urandom_range(0, 99) < 55);
            m_we = $urandom_range(0, 1) == 1;
            step(r_v, m_v, m_we, 32'($urandom_range(0, 15)), $urandom, p_v, p_we, p_addr, p_wd);
        end

        for (int i = 0; i < 256; i++) begin
            if (tb_mem[i] !== ref_mem[i]) check_eq("mem_final", tb_mem[i], ref_mem[i]);
        end
        check_eq("mem_final_44", tb_mem[44], ref_mem[44]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
